// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity-mode
// constants and the counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CHECK,
    ST_STOP
  } uart_state_e;

  localparam logic [31:0] PAR_NONE = "None";
  localparam logic [31:0] PAR_ODD  = {8'h00, "Odd"};
  localparam logic [31:0] PAR_EVEN = "Even";

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int uart_log2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer, falling-edge detector and bit-value decision for uart_rx.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote around the decision cycle.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rxd,
  output logic o_fall,
  output logic o_bit
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= i_rxd;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign o_fall = prev_q & ~s2_q;

`ifdef UART_RX_MAJORITY_EN
  // s1_q already holds the value s2_q will show next cycle, so the vote over
  // counts HALF-1/HALF/HALF+1 is ready on the same cycle as the single sample.
  assign o_bit = (prev_q & s2_q) | (prev_q & s1_q) | (s2_q & s1_q);
`else
  assign o_bit = s2_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: configurable data/parity/stop framing, one-cycle o_valid strobe.
// Optional macro UART_RX_MAJORITY_EN selects majority-vote bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [31:0] CHECK_BIT = PAR_NONE,
  parameter int          BPS       = 115200,
  parameter int          CLK       = 25_000_000,
  parameter int          DATA_BIT  = 8,
  parameter int          STOP_BIT  = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_rxd,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_valid,
  output logic                o_check_err,
  output logic                o_frame_err
);

  localparam int BIT_CNT = CLK / BPS;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = uart_log2(BIT_CNT);
  localparam int IW      = uart_log2((DATA_BIT > STOP_BIT) ? DATA_BIT : STOP_BIT);

  localparam logic [CW-1:0] HALF_C  = CW'(HALF);
  localparam logic [CW-1:0] LAST_C  = CW'(BIT_CNT - 1);
  localparam logic [IW-1:0] DLAST_C = IW'(DATA_BIT - 1);
  localparam logic [IW-1:0] SLAST_C = IW'(STOP_BIT - 1);
  localparam bit HAS_PAR = (CHECK_BIT != PAR_NONE);
  localparam bit IS_ODD  = (CHECK_BIT == PAR_ODD);

  uart_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_BIT-1:0] sh_q, sh_d;
  logic                perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                valid_q, valid_d, chk_q, chk_d, frm_q, frm_d;
  logic                fall, rx_bit, par_x;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_rxd   (i_rxd),
    .o_fall  (fall),
    .o_bit   (rx_bit)
  );

  assign par_x = (^sh_q) ^ rx_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    chk_d   = chk_q;
    frm_d   = frm_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = ST_START;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: if (cnt_q == HALF_C) begin
        cnt_d   = '0;
        state_d = rx_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (cnt_q == LAST_C) begin
        cnt_d = '0;
        sh_d  = {rx_bit, sh_q[DATA_BIT-1:1]};
        if (idx_q == DLAST_C) begin
          idx_d   = '0;
          state_d = HAS_PAR ? ST_CHECK : ST_STOP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_CHECK: if (cnt_q == LAST_C) begin
        cnt_d   = '0;
        perr_d  = IS_ODD ? ~par_x : par_x;
        state_d = ST_STOP;
      end
      ST_STOP: if (cnt_q == LAST_C) begin
        cnt_d  = '0;
        ferr_d = ferr_q | ~rx_bit;
        // Leave at mid-stop-bit so an immediately following start edge is seen.
        if (idx_q == SLAST_C) begin
          valid_d = 1'b1;
          data_d  = sh_q;
          chk_d   = perr_q;
          frm_d   = ferr_q | ~rx_bit;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      chk_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      chk_q   <= chk_d;
      frm_q   <= frm_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_check_err = chk_q;
  assign o_frame_err = frm_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (8N1, 8E1, 7O2 at a faster baud) on
// separate lines, table vectors, corner-case sequences and randomized frames.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rxd [3];
  logic       v0, v1, v2, ce0, ce1, ce2, fe0, fe1, fe2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  int         cyc = 0;
  int         n_asrt = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CHECK_BIT(PAR_NONE)) dn (
    .i_clk(clk), .i_reset(rst), .i_rxd(rxd[0]),
    .o_data(d0), .o_valid(v0), .o_check_err(ce0), .o_frame_err(fe0));
  uart_rx #(.CHECK_BIT(PAR_EVEN)) de (
    .i_clk(clk), .i_reset(rst), .i_rxd(rxd[1]),
    .o_data(d1), .o_valid(v1), .o_check_err(ce1), .o_frame_err(fe1));
  uart_rx #(.CHECK_BIT(PAR_ODD), .BPS(1_000_000), .DATA_BIT(7), .STOP_BIT(2)) dod (
    .i_clk(clk), .i_reset(rst), .i_rxd(rxd[2]),
    .o_data(d2), .o_valid(v2), .o_check_err(ce2), .o_frame_err(fe2));

  typedef struct {
    logic [7:0] data;
    logic       cerr;
    logic       ferr;
    int         cyc;
  } exp_t;

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       par;
    logic [1:0] stops;
    logic [7:0] e_data;
    logic       e_cerr;
    logic       e_ferr;
  } vec_t;

  exp_t expq [3][$];
  exp_t last [3];
  vec_t vecs [9];

  function automatic int bcnt(input int l); return (l == 2) ? 25 : 217; endfunction
  function automatic int ndat(input int l); return (l == 2) ? 7 : 8;    endfunction
  function automatic int npar(input int l); return (l == 0) ? 0 : 1;    endfunction
  function automatic int nstp(input int l); return (l == 2) ? 2 : 1;    endfunction

  // Reference: what a receiver configured like lane l must report for a frame.
  function automatic exp_t model(input int l, input logic [7:0] d, input logic par,
                                 input logic [1:0] st);
    exp_t e;
    int   ones;
    e.data = (ndat(l) == 7) ? {1'b0, d[6:0]} : d;
    ones   = $countones(e.data) + int'(par);
    e.cerr = (l == 1) ? (ones % 2 == 1) : (l == 2) ? (ones % 2 == 0) : 1'b0;
    e.ferr = (nstp(l) == 2) ? ~(st[0] & st[1]) : ~st[0];
    e.cyc  = 0;
    return e;
  endfunction

  // Drive one frame, one bit per bcnt cycles; inv_t inverts the line for one cycle.
  task automatic send(input int l, input logic [7:0] d, input logic par, input logic [1:0] st,
                      input int inv_t, input bit do_exp, input logic [7:0] ed,
                      input logic ece, input logic efe);
    int b, nb, k;
    logic [11:0] fr;
    exp_t e;
    b  = bcnt(l);
    nb = 1 + ndat(l) + npar(l) + nstp(l);
    fr = '1;
    fr[0] = 1'b0;
    k = 1;
    for (int i = 0; i < ndat(l); i++) begin fr[k] = d[i]; k++; end
    if (npar(l) != 0) begin fr[k] = par; k++; end
    for (int s = 0; s < nstp(l); s++) begin fr[k] = st[s]; k++; end
    if (do_exp) begin
      e.data = ed; e.cerr = ece; e.ferr = efe;
      // 2 sync stages + edge register + HALF count + output register
      e.cyc = cyc + 4 + b / 2 + (nb - 1) * b;
      expq[l].push_back(e);
    end
    for (int t = 0; t < nb * b; t++) begin
      rxd[l] = fr[t / b] ^ (t == inv_t);
      @(negedge clk);
    end
  endtask

  task automatic mon(input int l, input logic v, input logic [7:0] d, input logic ce,
                     input logic fe);
    exp_t e;
    if (v) begin
      n_asrt++;
      if (expq[l].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid lane%0d cyc=%0d data=%h", l, cyc, d);
      end else begin
        e = expq[l].pop_front();
        if (d !== e.data || ce !== e.cerr || fe !== e.ferr || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL frame lane%0d got data=%h cerr=%b ferr=%b cyc=%0d want data=%h cerr=%b ferr=%b cyc=%0d",
                   l, d, ce, fe, cyc, e.data, e.cerr, e.ferr, e.cyc);
        end
        last[l] = e;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, v0, d0, ce0, fe0);
    mon(1, v1, d1, ce1, fe1);
    mon(2, v2, {1'b0, d2}, ce2, fe2);
  end

  // Line idle: no pending frame, no strobe, outputs still hold the last frame.
  task automatic check_idle(input int l);
    logic v, ce, fe;
    logic [7:0] dd;
    case (l)
      0:       begin v = v0; dd = d0;          ce = ce0; fe = fe0; end
      1:       begin v = v1; dd = d1;          ce = ce1; fe = fe1; end
      default: begin v = v2; dd = {1'b0, d2}; ce = ce2; fe = fe2; end
    endcase
    n_asrt++;
    if (expq[l].size() != 0 || v !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_valid lane%0d pending=%0d valid=%b want pending=0 valid=0",
               l, expq[l].size(), v);
      expq[l].delete();
    end
    n_asrt++;
    if (dd !== last[l].data || ce !== last[l].cerr || fe !== last[l].ferr) begin
      n_fail++;
      $display("FAIL hold lane%0d got data=%h cerr=%b ferr=%b want data=%h cerr=%b ferr=%b",
               l, dd, ce, fe, last[l].data, last[l].cerr, last[l].ferr);
    end
  endtask

  task automatic rand_lane(input int l);
    logic [7:0] d;
    logic       par;
    logic [1:0] st;
    int         gap;
    exp_t       e;
    for (int n = 0; n < 6; n++) begin
      d   = 8'($urandom);
      par = ((l == 2) ? ~^d[6:0] : ^d) ^ ($urandom_range(3) == 0);
      st  = 2'b11;
      if ($urandom_range(3) == 0) st[$urandom_range(nstp(l) - 1)] = 1'b0;
      e = model(l, d, par, st);
      send(l, d, par, st, -1, 1'b1, e.data, e.cerr, e.ferr);
      gap = $urandom_range(3);
      // a low last stop bit needs the line seen high before the next start edge
      if (st[nstp(l) - 1] == 1'b0 && gap == 0) gap = 1;
      if (gap > 0) begin
        rxd[l] = 1'b1;
        repeat (gap) @(negedge clk);
      end
    end
    rxd[l] = 1'b1;
    repeat (20) @(negedge clk);
    check_idle(l);
  endtask

  localparam logic [7:0] INV_EXP =
`ifdef UART_RX_MAJORITY_EN
    8'h00;
`else
    8'h08;
`endif

  initial begin
    rst = 1'b1;
    for (int l = 0; l < 3; l++) begin
      rxd[l]  = 1'b1;
      last[l] = '{8'h00, 1'b0, 1'b0, 0};
    end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 3; l++) check_idle(l);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    vecs[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{0, 8'h55, 1'b0, 2'b10, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{2, 8'h2A, 1'b0, 2'b11, 8'h2A, 1'b0, 1'b0};
    vecs[5] = '{2, 8'h2A, 1'b1, 2'b11, 8'h2A, 1'b1, 1'b0};
    vecs[6] = '{2, 8'h7F, 1'b0, 2'b01, 8'h7F, 1'b0, 1'b1};
    vecs[7] = '{1, 8'h00, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{2, 8'h7F, 1'b1, 2'b10, 8'h7F, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].lane, vecs[i].data, vecs[i].par, vecs[i].stops, -1, 1'b1,
           vecs[i].e_data, vecs[i].e_cerr, vecs[i].e_ferr);
      rxd[vecs[i].lane] = 1'b1;
      repeat (20) @(negedge clk);
      check_idle(vecs[i].lane);
    end

    // 50-cycle glitch: START while counting to HALF, IDLE right after the check
    rxd[0] = 1'b0;
    repeat (50) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (108 + 3 - 50) @(negedge clk);
    n_asrt++;
    if (dn.state_q !== ST_START) begin
      n_fail++;
      $display("FAIL glitch_start state=%0d want %0d", dn.state_q, ST_START);
    end
    @(negedge clk);
    n_asrt++;
    if (dn.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL glitch_idle state=%0d want %0d", dn.state_q, ST_IDLE);
    end
    repeat (300) @(negedge clk);
    check_idle(0);

    // back-to-back frames, then a fourth frame cut short by reset
    send(0, 8'h01, 1'b0, 2'b11, -1, 1'b1, 8'h01, 1'b0, 1'b0);
    send(0, 8'h80, 1'b0, 2'b11, -1, 1'b1, 8'h80, 1'b0, 1'b0);
    send(0, 8'hFF, 1'b0, 2'b11, -1, 1'b1, 8'hFF, 1'b0, 1'b0);
    rxd[0] = 1'b0;
    repeat (217) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (3 * 217) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last[0] = '{8'h00, 1'b0, 1'b0, 0};
    repeat (2500) @(negedge clk);
    check_idle(0);

    // break: exactly one all-zero frame with a framing error, then recovery
    expq[0].push_back('{8'h00, 1'b0, 1'b1, cyc + 4 + 108 + 9 * 217});
    rxd[0] = 1'b0;
    repeat (3 * 10 * 217) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (300) @(negedge clk);
    check_idle(0);
    send(0, 8'h5A, 1'b0, 2'b11, -1, 1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_idle(0);

    // one-cycle inversion landing on the decision sample of data bit 3
    send(0, 8'h00, 1'b0, 2'b11, 1 + 108 + 4 * 217, 1'b1, INV_EXP, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_idle(0);

    fork
      rand_lane(0);
      rand_lane(1);
      rand_lane(2);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CHECK_BIT, default "None", meaning parity mode: "None", "Odd" or "Even".
REQ-002 The block SHALL have parameter BPS, default 115200, meaning the baud rate in bit/s.
REQ-003 The block SHALL have parameter CLK, default 25_000_000, meaning the i_clk frequency in Hz.
REQ-004 The block SHALL have parameter DATA_BIT, default 8, meaning the number of data bits (6, 7 or 8).
REQ-005 The block SHALL have parameter STOP_BIT, default 1, meaning the number of stop bits (integer, at least 1).
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_rxd, input, 1 bit: the asynchronous serial line, which idles high.
REQ-009 The block SHALL have port o_data, output, DATA_BIT bits: the received word, LSB first on the line.
REQ-010 The block SHALL have port o_valid, output, 1 bit: a one-cycle strobe marking that o_data and the error flags are valid.
REQ-011 The block SHALL have port o_check_err, output, 1 bit: parity mismatch, qualified by o_valid; it is always 0 when CHECK_BIT is "None".
REQ-012 The block SHALL have port o_frame_err, output, 1 bit: one or more stop bits sampled low, qualified by o_valid.

Function
REQ-013 Bit period SHALL be BIT_CNT = CLK/BPS cycles (integer division), mid-bit point HALF = BIT_CNT/2, with counter width derived from BIT_CNT by log2.
REQ-014 i_rxd SHALL pass through a 2-flop synchronizer; a falling edge SHALL be detected on the synchronized signal against its previous value.
REQ-015 The state machine SHALL have states IDLE, START, DATA, CHECK and STOP, with IDLE as the reset state.
REQ-016 In IDLE, a detected falling edge SHALL clear the bit counter and enter START.
REQ-017 In START, at count HALF, a sample of 1 SHALL return the block to IDLE with no o_valid (false start); a sample of 0 SHALL restart the counter and enter DATA.
REQ-018 In DATA, each sample SHALL be taken BIT_CNT cycles after the previous one and shifted in LSB first.
REQ-019 After DATA_BIT samples, DATA SHALL go to CHECK when CHECK_BIT is not "None", otherwise to STOP.
REQ-020 CHECK SHALL sample one parity bit; the error condition SHALL be: "Odd" errs when XOR(data, parity) is 0; "Even" errs when it is 1.
REQ-021 STOP SHALL sample STOP_BIT stop bits at BIT_CNT spacing; any 0 sample SHALL set the frame-error flag.
REQ-022 On the cycle after the last stop-bit sample, the block SHALL drive o_valid=1 for exactly one cycle, update o_data/o_check_err/o_frame_err, and return to IDLE.
REQ-023 o_data and the error flags SHALL hold their values until the next o_valid.
REQ-024 Returning to IDLE at mid-stop-bit is required, so back-to-back frames with no idle gap are received without loss.
REQ-025 There SHALL be no backpressure; frames SHALL NOT be buffered.
REQ-026 A line held low (break) SHALL produce one frame with o_frame_err=1; no new frame SHALL start until the line has been seen high and then a falling edge occurs.

Reset
REQ-027 While i_reset is high on a clock edge, the block SHALL force state IDLE, clear the counters and the shift register, and set o_data=0, o_valid=0, o_check_err=0, o_frame_err=0, with both synchronizer flops at 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no o_valid SHALL be produced for it.

Configuration
REQ-029 With macro UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of samples at counts HALF-1, HALF and HALF+1; the decision time and all timing SHALL stay as without the macro.
REQ-030 Without UART_RX_MAJORITY_EN, each bit value SHALL be the single sample at count HALF.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enumeration, the parity-mode string constants and the log2 width function, for reuse with the transmitter.
REQ-032 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and the falling-edge detector; uart_rx SHALL instantiate it once.

Verification (CLK=25_000_000, BPS=115200, BIT_CNT=217)
REQ-033 Sending 0xA5 with "None", 8N1 SHALL give o_valid for exactly 1 cycle with o_data=0xA5, o_check_err=0, o_frame_err=0, one cycle after mid stop bit.
REQ-034 With "Even", sending 0x3C with parity 0 SHALL give o_check_err=0; the same frame with parity 1 SHALL give o_data=0x3C and o_check_err=1.
REQ-035 A 50-cycle low glitch on an idle line SHALL produce no o_valid, and the state SHALL be IDLE by cycle HALF+3 after the glitch edge.
REQ-036 Sending 0x55 with the stop bit driven 0 SHALL give o_data=0x55 and o_frame_err=1.
REQ-037 Three back-to-back frames 0x01, 0x80, 0xFF with no gap SHALL produce three o_valid strobes carrying the correct data; i_reset pulsed during the data bits of a fourth frame SHALL produce no o_valid for it.
REQ-038 With UART_RX_MAJORITY_EN, a 1-cycle inversion of i_rxd (accounting for synchronizer delay) at the mid-bit point of bit 3 of 0x00 SHALL still give o_data=0x00.
